// File: rtl/pixel_stream_framer.sv
// pixel_stream_framer: tags raw pixels with frame position and emits
// a registered sop/eop framed stream, flagging truncated frames.
module pixel_stream_framer #(
    parameter int DATA_W  = 8,
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480,
    parameter int COL_W   = 10,
    parameter int ROW_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_in_vld,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_NUM - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_NUM - 1);

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col_cnt;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_cnt;
    logic [ROW_W-1:0] row_nxt;

    logic             accept;
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic             is_first;
    logic             is_last;
    logic             trunc;

    // Position of this cycle's pixel; frame_start overrides the counters.
    always_comb begin
        accept   = pix_in_vld && ((state == ACTIVE) || frame_start);
        pos_col  = frame_start ? '0 : col_cnt;
        pos_row  = frame_start ? '0 : row_cnt;
        is_first = (pos_col == '0) && (pos_row == '0);
        is_last  = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
        trunc    = frame_start && (state == ACTIVE)
                   && ((col_cnt != '0) || (row_cnt != '0));
    end

    // Next state and counter advance.
    always_comb begin
        state_nxt = state;
        col_nxt   = col_cnt;
        row_nxt   = row_cnt;
        if (frame_start) begin
            state_nxt = ACTIVE;
            col_nxt   = '0;
            row_nxt   = '0;
        end
        if (accept) begin
            if (is_last) begin
                state_nxt = IDLE;
                col_nxt   = '0;
                row_nxt   = '0;
            end else if (pos_col == COL_LAST) begin
                state_nxt = ACTIVE;
                col_nxt   = '0;
                row_nxt   = pos_row + 1'b1;
            end else begin
                state_nxt = ACTIVE;
                col_nxt   = pos_col + 1'b1;
                row_nxt   = pos_row;
            end
        end
    end

    // State and position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
        end
    end

    // Registered output stage; dout holds when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                dout <= pix_in;
            end
            dout_vld  <= accept;
            dout_sop  <= accept && is_first;
            dout_eop  <= accept && is_last;
            frame_err <= trunc;
        end
    end

    assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_pixel_stream_framer.sv
// tb_pixel_stream_framer: directed vectors on a 4x3 geometry with
// hand-computed expected beats, sop/eop, busy and frame_err.
module tb_pixel_stream_framer;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic [7:0] pix_in;
    logic       pix_in_vld;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_sop;
    logic       dout_eop;
    logic       busy;
    logic       frame_err;

    int         checks;
    int         failures;
    logic [7:0] held;

    pixel_stream_framer #(
        .DATA_W (8),
        .COL_NUM(4),
        .ROW_NUM(3),
        .COL_W  (2),
        .ROW_W  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .pix_in     (pix_in),
        .pix_in_vld (pix_in_vld),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Drive one cycle and check the registered result after the edge.
    task automatic cyc(input string tag, input logic fs, input logic vld,
                       input logic [7:0] pix, input logic e_vld,
                       input logic e_sop, input logic e_eop,
                       input logic e_err, input logic e_busy);
        @(negedge clk);
        frame_start = fs;
        pix_in_vld  = vld;
        pix_in      = pix;
        @(posedge clk);
        #1;
        if (e_vld) held = pix;
        check({tag, ".vld"}, 32'(dout_vld), 32'(e_vld));
        check({tag, ".sop"}, 32'(dout_sop), 32'(e_sop));
        check({tag, ".eop"}, 32'(dout_eop), 32'(e_eop));
        check({tag, ".err"}, 32'(frame_err), 32'(e_err));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".dout"}, 32'(dout), 32'(held));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".dout"}, 32'(dout), 32'h0);
        check({tag, ".vld"}, 32'(dout_vld), 32'h0);
        check({tag, ".sop"}, 32'(dout_sop), 32'h0);
        check({tag, ".eop"}, 32'(dout_eop), 32'h0);
        check({tag, ".err"}, 32'(frame_err), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        held        = 8'h00;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_in_vld  = 1'b0;
        pix_in      = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1. basic frame
        cyc("t1.p0", 1, 1, 8'h00, 1, 1, 0, 0, 1);
        for (int i = 1; i < 12; i++)
            cyc("t1.px", 0, 1, 8'(i), 1, 0, i == 11, 0, i != 11);
        cyc("t1.idle", 0, 0, 8'h00, 0, 0, 0, 0, 0);

        // 2. gapped input
        for (int i = 0; i < 12; i++) begin
            cyc("t2.px", i == 0, 1, 8'(i), 1, i == 0, i == 11, 0, i != 11);
            cyc("t2.gap", 0, 0, 8'hEE, 0, 0, 0, 0, i != 11);
        end

        // 3. idle drop, then a frame starting at 0x55
        for (int i = 0; i < 5; i++)
            cyc("t3.drop", 0, 1, 8'(8'h10 + i), 0, 0, 0, 0, 0);
        cyc("t3.sop", 1, 1, 8'h55, 1, 1, 0, 0, 1);
        for (int i = 1; i < 6; i++)
            cyc("t3.px", 0, 1, 8'(8'h60 + i), 1, 0, 0, 0, 1);

        // 4. truncation after 6 pixels
        cyc("t4.trunc", 1, 1, 8'hAA, 1, 1, 0, 1, 1);
        for (int i = 1; i < 12; i++)
            cyc("t4.px", 0, 1, 8'(8'hA0 + i), 1, 0, i == 11, 0, i != 11);

        // 5. frame_start coincident with the last pixel
        cyc("t5.p0", 1, 1, 8'h00, 1, 1, 0, 0, 1);
        for (int i = 1; i < 11; i++)
            cyc("t5.px", 0, 1, 8'(i), 1, 0, 0, 0, 1);
        cyc("t5.coinc", 1, 1, 8'h0B, 1, 1, 0, 1, 1);

        // 6. async reset mid-frame after pixel 5
        for (int i = 1; i < 6; i++)
            cyc("t6.px", 0, 1, 8'(8'h20 + i), 1, 0, 0, 0, 1);
        @(negedge clk);
        rst_n      = 1'b0;
        pix_in_vld = 1'b1;
        pix_in     = 8'h99;
        #1;
        check_reset_outputs("t6.rst0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("t6.rst");
        end
        @(negedge clk);
        rst_n      = 1'b1;
        pix_in_vld = 1'b0;
        held       = 8'h00;
        for (int i = 0; i < 4; i++)
            cyc("t6.drop", 0, 1, 8'(8'h30 + i), 0, 0, 0, 0, 0);
        cyc("t6.sop", 1, 1, 8'h77, 1, 1, 0, 0, 1);
        for (int i = 1; i < 12; i++)
            cyc("t6.px", 0, 1, 8'(8'h70 + i), 1, 0, i == 11, 0, i != 11);
        cyc("t6.idle", 0, 0, 8'h00, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_stream_framer.md
Name: pixel_stream_framer

Overview:
- Source end of the 8-bit pixel stream (dout/dout_vld/dout_sop/dout_eop) consumed by the filter stages.
- Takes untagged pixels plus a frame-start pulse from the capture/grayscale front end and emits a framed stream.
- Output is registered. dout_sop marks the first pixel of a frame and dout_eop the last.
- Counts columns and rows against the configured geometry.
- Discards pixels outside a frame and flags truncated frames.

Parameters:
DATA_W  8    pixel width
COL_NUM 640  pixels per row
ROW_NUM 480  rows per frame
COL_W   10   column counter width, must satisfy 2^COL_W >= COL_NUM
ROW_W   9    row counter width, must satisfy 2^ROW_W >= ROW_NUM

Ports:
clk          input   1       system clock
rst_n        input   1       asynchronous active-low reset
frame_start  input   1       1-cycle pulse; the pixel in the same cycle (if valid) is pixel 0 of a new frame
pix_in       input   DATA_W  raw pixel
pix_in_vld   input   1       pix_in valid this cycle
dout         output  DATA_W  framed pixel
dout_vld     output  1       dout valid
dout_sop     output  1       first pixel of frame, qualified by dout_vld
dout_eop     output  1       last pixel of frame, qualified by dout_vld
busy         output  1       1 while in state ACTIVE
frame_err    output  1       1-cycle pulse when a frame is truncated by a new frame_start

Behaviour:
Clock and reset
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, col_cnt=0, row_cnt=0, all outputs 0 (dout=0).
- Reset mid-frame: the frame is abandoned. No eop and no frame_err are emitted. The first pixel accepted after reset requires a new frame_start.

State machine
- IDLE:
  - pix_in_vld without frame_start: pixel dropped, dout_vld=0.
  - frame_start=1: go to ACTIVE, counters cleared.
- ACTIVE: every accepted pixel advances the counters.
  - col_cnt wraps COL_NUM-1 -> 0, and row_cnt increments on that wrap.
  - Accepting the pixel at col=COL_NUM-1, row=ROW_NUM-1 returns the block to IDLE, with counters at 0.
- busy = (state==ACTIVE).

Acceptance and tagging
- A pixel is accepted when pix_in_vld=1 and either (state==ACTIVE) or (frame_start=1).
- frame_start has priority over the counters: the same-cycle pixel is tagged at col=0, row=0.
- Latency is exactly 1 cycle. The cycle after an accepted pixel:
  - dout=pix_in, dout_vld=1;
  - dout_sop=1 iff its position was (0,0);
  - dout_eop=1 iff its position was (COL_NUM-1, ROW_NUM-1).
- Cycle after a non-accepted cycle: dout_vld=dout_sop=dout_eop=0. dout holds its last value.
- sop and eop are never 1 without dout_vld.
- Degenerate geometry COL_NUM=ROW_NUM=1: sop and eop are asserted together on each frame's single pixel.

frame_start while ACTIVE
- If at least one pixel of the current frame has been accepted (counters != 0,0): frame_err=1 for one cycle, registered with the same 1-cycle latency as the data.
- Counters restart at (0,0) in all cases. The same-cycle pixel, if valid, becomes sop of the new frame.
- The truncated frame never gets an eop.
- If no pixel has yet been accepted: no error, simple restart.
- frame_start coincident with the final pixel of a frame: that pixel is sop of the new frame, not eop of the old one, and frame_err pulses.

frame_start with pix_in_vld=0
- Enters or restarts ACTIVE; no output is produced that cycle.

Gaps
- pix_in_vld may deassert for any number of cycles inside a frame. Counters hold and the state does not change.

Test Plan:
Params COL_NUM=4, ROW_NUM=3.
1. Basic frame: frame_start with pixel 0x00, then 11 consecutive pixels 0x01..0x0B.
   -> 12 dout_vld beats 0x00..0x0B; sop on 0x00 only; eop on 0x0B only; busy falls the cycle after 0x0B is accepted; frame_err=0.
2. Gapped input: the same 12 pixels with pix_in_vld toggling 1,0,1,0...
   -> identical data, sop and eop; each beat 1 cycle after its input; no extra beats.
3. Idle drop: 5 valid pixels with no frame_start, then frame_start+0x55.
   -> first output beat is 0x55 with sop=1; the 5 earlier pixels are never output.
4. Truncation: after 6 pixels, frame_start+0xAA.
   -> frame_err pulses once, coincident with the 0xAA beat, which carries sop=1; eop then falls on the 12th pixel counted from 0xAA.
5. Coincident end: frame_start asserted on the 12th pixel (0x0B).
   -> 0x0B is output with sop=1, eop=0; frame_err=1; busy stays 1.
6. Async reset mid-frame: assert rst_n=0 after pixel 5 for 3 cycles, release, then feed valid pixels without frame_start.
   -> all outputs 0 during reset; no output after release until the next frame_start; no eop and no frame_err for the abandoned frame.
